// File: rtl/key_pio_in.sv
// Avalon-MM input PIO for active-low push-buttons: per-key sync + debounce,
// falling-edge capture with write-1-to-clear, and a masked level interrupt.

module key_pio_lane #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic deb,
  output logic fall
);
  logic             s1, s2, deb_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      deb   <= 1'b1;
      deb_d <= 1'b1;
      cnt   <= '0;
    end else begin
      s1    <= pin;
      s2    <= s1;
      deb_d <= deb;
      // Any cycle where the synced pin agrees with deb restarts the count,
      // so only an uninterrupted run of DEBOUNCE_CYCLES mismatches flips deb.
      if (s2 == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        deb <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Press = debounced 1->0; registered so capture lands the cycle after deb moves.
  assign fall = deb_d & ~deb;
endmodule

module key_pio_in #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  localparam logic [1:0] A_DATA = 2'd0, A_MASK = 2'd2, A_EDGE = 2'd3;

  logic [WIDTH-1:0] deb, fall, irqmask, edgecap, clr;
  logic             wr_en, rd_en;
  logic [31:0]      rd_mux;
  logic             unused_wd;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    key_pio_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_lane (
      .clk    (clk),
      .reset_n(reset_n),
      .pin    (in_port[i]),
      .deb    (deb[i]),
      .fall   (fall[i])
    );
  end

  assign wr_en     = chipselect & ~write_n;
  assign rd_en     = chipselect & ~read_n;
  assign clr       = (wr_en && address == A_EDGE) ? writedata[WIDTH-1:0] : '0;
  assign unused_wd = &{1'b0, writedata};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask <= '0;
      edgecap <= '0;
    end else begin
      if (wr_en && address == A_MASK) irqmask <= writedata[WIDTH-1:0];
      // A new press outranks a simultaneous clear of the same bit.
      edgecap <= (edgecap & ~clr) | fall;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      A_DATA:  rd_mux[WIDTH-1:0] = deb;
      A_MASK:  rd_mux[WIDTH-1:0] = irqmask;
      A_EDGE:  rd_mux[WIDTH-1:0] = edgecap;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   readdata <= '0;
    else if (rd_en) readdata <= rd_mux;
  end

  assign irq = |(edgecap & irqmask);
endmodule

// File: tb/tb_key_pio_in.sv
// Directed bench for key_pio_in: register table plus debounce/edge/reset sequences.

module tb_key_pio_in;
  localparam int WIDTH = 4;
  localparam int DEB   = 4;
  localparam int LAT   = 2 + DEB + 1;  // pin change to readdata of DATA with a read held

  logic             clk = 1'b0;
  logic             reset_n;
  logic [1:0]       address;
  logic             chipselect, read_n, write_n;
  logic [31:0]      writedata;
  logic [WIDTH-1:0] in_port;
  logic [31:0]      readdata;
  logic             irq;

  int checks   = 0;
  int failures = 0;

  key_pio_in #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEB), .CNT_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .in_port(in_port), .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    logic        exp_irq;
    string       name;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic wr, input logic [1:0] addr, input logic [31:0] data,
                              input logic [31:0] exp_rd, input logic exp_irq, input string name);
    vec_t v;
    v.wr = wr; v.addr = addr; v.data = data; v.exp_rd = exp_rd; v.exp_irq = exp_irq; v.name = name;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1; address = 2'd0; writedata = '0;
  endtask

  task automatic run_vec(input vec_t v);
    chipselect = 1'b1; address = v.addr; writedata = v.data;
    read_n = v.wr; write_n = ~v.wr;
    tick();
    idle();
    if (!v.wr) chk({v.name, " rd"}, readdata, v.exp_rd);
    chk({v.name, " irq"}, {31'd0, irq}, {31'd0, v.exp_irq});
  endtask

  task automatic run_tbl();
    foreach (tbl[i]) run_vec(tbl[i]);
    tbl.delete();
  endtask

  // Holds a DATA read and counts cycles until key b reads pressed.
  task automatic measure_fall(input int b, input string name);
    int n = 0;
    chipselect = 1'b1; read_n = 1'b0; address = 2'd0;
    do begin
      tick();
      n++;
    end while (readdata[b] !== 1'b0 && n < 20);
    idle();
    chk(name, n, LAT);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    idle();
    in_port = '1;
    reset_n = 1'b0;
    wait_cycles(3);
    chk("reset readdata", readdata, 32'h0);
    chk("reset irq", {31'd0, irq}, 32'h0);
    reset_n = 1'b1;
    tick();

    // Reset values and bit masking above WIDTH
    tbl.push_back(mk(0, 0, 0, 32'h0000000F, 0, "data reset"));
    tbl.push_back(mk(0, 1, 0, 32'h0, 0, "rsvd reset"));
    tbl.push_back(mk(0, 2, 0, 32'h0, 0, "mask reset"));
    tbl.push_back(mk(0, 3, 0, 32'h0, 0, "edge reset"));
    tbl.push_back(mk(1, 2, 32'hFFFF_FFF5, 0, 0, "mask wr"));
    tbl.push_back(mk(0, 2, 0, 32'h5, 0, "mask upper0"));
    tbl.push_back(mk(1, 2, 32'h0, 0, 0, "mask clr"));
    tbl.push_back(mk(1, 0, 32'h0, 0, 0, "data wr"));
    tbl.push_back(mk(0, 0, 0, 32'hF, 0, "data ro"));
    tbl.push_back(mk(1, 1, 32'hFF, 0, 0, "rsvd wr"));
    tbl.push_back(mk(0, 1, 0, 32'h0, 0, "rsvd ro"));
    run_tbl();

    // Press key0: DATA moves after sync + debounce, capture one cycle later
    in_port = 4'b1110;
    measure_fall(0, "key0 latency");
    chk("key0 irq masked", {31'd0, irq}, 32'h0);
    tbl.push_back(mk(0, 3, 0, 32'h1, 0, "key0 edge"));
    tbl.push_back(mk(0, 3, 0, 32'h1, 0, "edge read keeps"));
    tbl.push_back(mk(1, 2, 32'h1, 0, 1, "mask0 irq"));
    tbl.push_back(mk(1, 2, 32'h0, 0, 0, "unmask irq off"));
    tbl.push_back(mk(1, 2, 32'h1, 0, 1, "remask irq on"));
    tbl.push_back(mk(1, 3, 32'h1, 0, 0, "w1c irq off"));
    tbl.push_back(mk(0, 3, 0, 32'h0, 0, "w1c edge"));
    run_tbl();

    // Release key0: no capture on rising debounced edge
    in_port = 4'b1111;
    wait_cycles(LAT + 2);
    tbl.push_back(mk(0, 0, 0, 32'hF, 0, "release data"));
    tbl.push_back(mk(0, 3, 0, 32'h0, 0, "release edge"));
    run_tbl();

    // 3-cycle glitch on key2 is rejected
    in_port = 4'b1011;
    wait_cycles(3);
    in_port = 4'b1111;
    wait_cycles(LAT + 2);
    tbl.push_back(mk(0, 0, 0, 32'hF, 0, "glitch data"));
    tbl.push_back(mk(0, 3, 0, 32'h0, 0, "glitch edge"));
    run_tbl();
    in_port = 4'b1011;
    measure_fall(2, "key2 latency after glitch");
    in_port = 4'b1111;
    wait_cycles(LAT + 2);
    tbl.push_back(mk(1, 3, 32'hF, 0, 0, "clr key2"));
    tbl.push_back(mk(0, 3, 0, 32'h0, 0, "clr key2 rd"));
    run_tbl();

    // Key1 capture coincides with a W1C of bit1: set wins
    in_port = 4'b1101;
    wait_cycles(2 + DEB);
    chipselect = 1'b1; write_n = 1'b0; address = 2'd3; writedata = 32'h2;
    tick();
    idle();
    tbl.push_back(mk(0, 3, 0, 32'h2, 0, "set wins"));
    tbl.push_back(mk(1, 3, 32'h0, 0, 0, "w1c zero"));
    tbl.push_back(mk(0, 3, 0, 32'h2, 0, "w1c zero keeps"));
    tbl.push_back(mk(1, 2, 32'hF, 0, 1, "mask all irq"));
    run_tbl();
    in_port = 4'b1111;
    wait_cycles(LAT + 2);

    // Key3 mid-count (counter=2), then 1-cycle reset
    in_port = 4'b0111;
    wait_cycles(4);
    reset_n = 1'b0;
    #1;
    chk("midreset irq", {31'd0, irq}, 32'h0);
    chk("midreset readdata", readdata, 32'h0);
    tick();
    reset_n = 1'b1;
    measure_fall(3, "key3 latency after reset");
    chk("postreset irq", {31'd0, irq}, 32'h0);
    tbl.push_back(mk(0, 2, 0, 32'h0, 0, "postreset mask"));
    tbl.push_back(mk(0, 3, 0, 32'h8, 0, "postreset edge"));
    tbl.push_back(mk(0, 1, 0, 32'h0, 0, "postreset rsvd"));
    run_tbl();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
